// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write register file with bypass, zero register and bulk clear
module reg_file_2r1w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  ra_data,
    output logic [WIDTH-1:0]  rb_data,
    input  logic              clr_start,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wr_en;

    assign busy = (state == CLEAR);

    // A write that would land on the hardwired zero register is treated as no write at all,
    // which also keeps it out of the bypass path.
    assign wr_en = we && !busy && !reset && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && wr_en && (waddr == addr)) begin
            return wdata;
        end else begin
            return mem[addr];
        end
    endfunction

    always_comb begin
        ra_data = read_port(ra_addr);
        rb_data = read_port(rb_addr);
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - randomized and directed bench for reg_file_2r1w against a reference model
module tb_reg_file_2r1w;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [WIDTH-1:0]  wdata = '0;
    logic [ADDR_W-1:0] ra_addr = '0;
    logic [ADDR_W-1:0] rb_addr = '0;
    logic              clr_start = 1'b0;
    logic [WIDTH-1:0]  ra0, rb0, ra1, rb1;
    logic              busy0, busy1;

    int checks = 0;
    int failures = 0;

    // Instance 0: plain register 0, bypass on. Instance 1: hardwired zero, no bypass.
    reg_file_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra0), .rb_data(rb0),
        .clr_start(clr_start), .busy(busy0)
    );

    reg_file_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_alt (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra1), .rb_data(rb1),
        .clr_start(clr_start), .busy(busy1)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] m_mem [2][DEPTH];
    bit               m_zero [2] = '{1'b0, 1'b1};
    bit               m_byp  [2] = '{1'b1, 1'b0};
    int               m_clear_pos = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_read(input int k, input logic [ADDR_W-1:0] addr);
        if (m_zero[k] && addr == 0) return '0;
        if (reset) return '0;
        if (m_byp[k] && we && m_clear_pos < 0 && waddr == addr && !(m_zero[k] && waddr == 0))
            return wdata;
        return m_mem[k][addr];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
        m_clear_pos = -1;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_clear_pos >= 0) begin
            for (int k = 0; k < 2; k++) m_mem[k][m_clear_pos] = '0;
            m_clear_pos = (m_clear_pos == DEPTH - 1) ? -1 : m_clear_pos + 1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we && !(m_zero[k] && waddr == 0)) m_mem[k][waddr] = wdata;
            if (clr_start) m_clear_pos = 0;
        end
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1ns later, then the
    // model follows the rising edge and the task returns on the next falling edge.
    task automatic cycle();
        #1;
        check("ra0", ra0, model_read(0, ra_addr));
        check("rb0", rb0, model_read(0, rb_addr));
        check("ra1", ra1, model_read(1, ra_addr));
        check("rb1", rb1, model_read(1, rb_addr));
        check("busy0", busy0, m_clear_pos >= 0);
        check("busy1", busy1, m_clear_pos >= 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic write(input int a, input int d);
        we = 1'b1; waddr = ADDR_W'(a); wdata = WIDTH'(d);
        cycle();
        we = 1'b0;
    endtask

    int n;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy0, 0);
        check("reset_ra", ra0, 0);
        reset = 1'b0;
        @(negedge clk);

        // Every address on both ports after reset
        for (int i = 0; i < DEPTH; i++) begin
            ra_addr = ADDR_W'(i); rb_addr = ADDR_W'(DEPTH - 1 - i);
            cycle();
        end

        // Independent reads and same-register reads
        write(3, 8'hA5);
        write(6, 8'h3C);
        ra_addr = 3; rb_addr = 6;
        #1;
        check("t2_ra", ra0, 8'hA5);
        check("t2_rb", rb0, 8'h3C);
        cycle();
        rb_addr = 3;
        cycle();

        // Bypass versus no bypass
        write(2, 8'h11);
        we = 1'b1; waddr = 2; wdata = 8'h77; ra_addr = 2;
        #1;
        check("t3_byp", ra0, 8'h77);
        check("t3_nobyp", ra1, 8'h11);
        cycle();
        we = 1'b0;
        #1;
        check("t3_after", ra1, 8'h77);
        cycle();

        // Register 0 writes
        we = 1'b1; waddr = 0; wdata = 8'hFF; ra_addr = 0;
        #1;
        check("t4_zero_wc", ra1, 8'h00);
        check("t4_plain_wc", ra0, 8'hFF);
        cycle();
        we = 1'b0;
        #1;
        check("t4_zero", ra1, 8'h00);
        check("t4_plain", ra0, 8'hFF);
        cycle();

        // Bulk clear with dropped write and ignored re-trigger
        for (int i = 0; i < DEPTH; i++) write(i, 8'h10 + i);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        n = 0;
        while (busy0 && n < 40) begin
            we = 1'b0; clr_start = 1'b0;
            if (n == 3) begin
                ra_addr = 2; rb_addr = 3;
                we = 1'b1; waddr = 7; wdata = 8'h99;
                #1;
                check("t5_r2", ra0, 8'h00);
                check("t5_r3", rb0, 8'h13);
            end
            if (n == 4) clr_start = 1'b1;
            cycle();
            n++;
        end
        we = 1'b0; clr_start = 1'b0;
        check("t5_busy_len", n, DEPTH);
        ra_addr = 7; rb_addr = 0;
        #1;
        check("t5_r7", ra0, 8'h00);
        cycle();

        // Asynchronous reset in the middle of a clear
        write(5, 8'h55);
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        ra_addr = 5;
        cycle();
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check("t6_r5", ra0, 8'h00);
        check("t6_busy", busy0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        write(1, 8'h42);
        ra_addr = 1;
        #1;
        check("t6_r1", ra0, 8'h42);
        check("t6_busy_after", busy0, 0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = ADDR_W'($urandom);
            wdata     = WIDTH'($urandom);
            ra_addr   = ADDR_W'($urandom);
            rb_addr   = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom);
            clr_start = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
